// File: rtl/sys_clk_pkg.sv
// sys_clk_pkg: shared constants and helpers for the PLL stand-in clock tree.
package sys_clk_pkg;

    localparam int CNT_W           = 8;
    localparam int LOCK_W          = 16;
    localparam int DIV0_DEF        = 25;
    localparam int DIV1_DEF        = 5;
    localparam int DIV2_DEF        = 6;
    localparam int DIV3_DEF        = 6;
    localparam int PHASE3_DEF      = 3;
    localparam int DIV4_DEF        = 6;
    localparam int LOCK_CYCLES_DEF = 1024;
    localparam int OSC_DIV_DEF     = 8;

    // Odd ratios stay high one extra cycle.
    function automatic int high_cycles(input int div);
        return (div + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: registered integer clock divider with clear (en_i) and freeze (run_i).
module clk_div_chan
    import sys_clk_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int PRELOAD = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic run_i,
    output logic clk_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HIGH = CNT_W'(high_cycles(DIV));
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(PRELOAD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q;
    logic             out_q, out_d;

    // The first enabled cycle shows PRELOAD so all channels start phase-aligned.
    always_comb begin
        cnt_d = !en_i ? '0 : !act_q ? PRE : !run_i ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        out_d = en_i && run_i && (cnt_d < HIGH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            act_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= en_i;
            out_q <= out_d;
        end
    end

    assign clk_o = out_q;

endmodule

// File: rtl/sys_clk_pll_model.sv
// sys_clk_pll_model: digital PLL stand-in; lock timer plus five divided clocks and an oscillator.
module sys_clk_pll_model
    import sys_clk_pkg::*;
#(
    parameter int DIV0        = DIV0_DEF,
    parameter int DIV1        = DIV1_DEF,
    parameter int DIV2        = DIV2_DEF,
    parameter int DIV3        = DIV3_DEF,
    parameter int PHASE3      = PHASE3_DEF,
    parameter int DIV4        = DIV4_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int OSC_DIV     = OSC_DIV_DEF
) (
    input  logic iCLK,
    input  logic iRESETn,
    input  logic iARESET,
    input  logic iOSCENA,
    output logic oC0,
    output logic oC1,
    output logic oC2,
    output logic oC3,
    output logic oC4,
    output logic oLOCKED,
    output logic oOSC_CLK
);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam int                PRE3      = (DIV3 - PHASE3) % DIV3;

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              at_last;

    // iARESET dominates a coincident terminal count.
    always_comb begin
        at_last    = (lock_cnt_q == LOCK_LAST);
        locked_d   = !iARESET && (locked_q || at_last);
        lock_cnt_d = iARESET ? '0 : (locked_q || at_last) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign oLOCKED = locked_q;

    clk_div_chan #(.DIV(DIV0), .PRELOAD(0)) u_c0 (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(locked_d), .run_i(1'b1), .clk_o(oC0)
    );
    clk_div_chan #(.DIV(DIV1), .PRELOAD(0)) u_c1 (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(locked_d), .run_i(1'b1), .clk_o(oC1)
    );
    clk_div_chan #(.DIV(DIV2), .PRELOAD(0)) u_c2 (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(locked_d), .run_i(1'b1), .clk_o(oC2)
    );
    clk_div_chan #(.DIV(DIV3), .PRELOAD(PRE3)) u_c3 (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(locked_d), .run_i(1'b1), .clk_o(oC3)
    );
    clk_div_chan #(.DIV(DIV4), .PRELOAD(0)) u_c4 (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(locked_d), .run_i(1'b1), .clk_o(oC4)
    );
    clk_div_chan #(.DIV(OSC_DIV), .PRELOAD(0)) u_osc (
        .clk_i(iCLK), .rst_ni(iRESETn), .en_i(1'b1), .run_i(iOSCENA), .clk_o(oOSC_CLK)
    );

endmodule

// File: tb/tb_sys_clk_pll_model.sv
// tb_sys_clk_pll_model: randomized bench against a cycle-count based model of the clock tree.
module tb_sys_clk_pll_model;

    localparam int LOCK = 1024;
    localparam int D0 = 25, D1 = 5, D2 = 6, D3 = 6, PH3 = 3, D4 = 6, DOSC = 8;

    logic iCLK = 1'b0, iRESETn = 1'b1, iARESET = 1'b0, iOSCENA = 1'b1;
    logic oC0, oC1, oC2, oC3, oC4, oLOCKED, oOSC_CLK;

    int   n_chk = 0, n_fail = 0;
    bit   osc_rand = 1'b0;
    int   age = 0, osc_n = 0;
    logic e_lock = 1'b0, e_osc = 1'b0;
    logic [4:0] e_c = '0;

    sys_clk_pll_model dut (
        .iCLK(iCLK), .iRESETn(iRESETn), .iARESET(iARESET), .iOSCENA(iOSCENA),
        .oC0(oC0), .oC1(oC1), .oC2(oC2), .oC3(oC3), .oC4(oC4),
        .oLOCKED(oLOCKED), .oOSC_CLK(oOSC_CLK)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic wave(input int t, input int div);
        return (t % div) < (div + 1) / 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge iCLK);
            if (osc_rand) iOSCENA = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Model: age counts edges since the last reset/iARESET; clocks are pure functions of age.
    always @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            age = 0; osc_n = 0; e_lock = 1'b0; e_c = '0; e_osc = 1'b0;
        end else begin
            age    = iARESET ? 0 : age + 1;
            e_lock = (age >= LOCK);
            e_c[0] = e_lock && wave(age - LOCK, D0);
            e_c[1] = e_lock && wave(age - LOCK, D1);
            e_c[2] = e_lock && wave(age - LOCK, D2);
            e_c[3] = e_lock && wave(age - LOCK + D3 - PH3, D3);
            e_c[4] = e_lock && wave(age - LOCK, D4);
            if (iOSCENA) osc_n++;
            e_osc  = iOSCENA && wave(osc_n - 1, DOSC);
        end
    end

    always @(negedge iCLK) begin
        chk1("m_locked", oLOCKED, e_lock);
        chk1("m_c0", oC0, e_c[0]);
        chk1("m_c1", oC1, e_c[1]);
        chk1("m_c2", oC2, e_c[2]);
        chk1("m_c3", oC3, e_c[3]);
        chk1("m_c4", oC4, e_c[4]);
        chk1("m_osc", oOSC_CLK, e_osc);
    end

    int         r [5] = '{default: 0};
    logic [4:0] prev = '0, cur;
    logic [7:0] c1p = '0, c2p = '0, c3p = '0;
    int         anti = 0, hi = 0, lo = 0;
    bit         found = 1'b0;

    initial begin
        #1 iRESETn = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("reset_outs", 32'({oLOCKED, oC4, oC3, oC2, oC1, oC0, oOSC_CLK}), 32'h0);
        iRESETn = 1'b1;
        step(1);
        osc_rand = 1'b1;
        step(1022);
        chk1("pre_lock", oLOCKED, 1'b0);
        chk("pre_lock_clks", 32'({oC4, oC3, oC2, oC1, oC0}), 32'h0);
        step(1);
        chk1("lock_at_1024", oLOCKED, 1'b1);
        chk("lock_align", 32'({oC4, oC3, oC2, oC1, oC0}), 32'h17);
        for (int i = 0; i < 600; i++) begin
            cur = {oC4, oC3, oC2, oC1, oC0};
            for (int k = 0; k < 5; k++) if (cur[k] && !prev[k]) r[k]++;
            if (i < 5) c1p[i] = oC1;
            if (i < 6) begin c2p[i] = oC2; c3p[i] = oC3; end
            if (i >= 3 && oC3 == oC2) anti++;
            prev = cur;
            step(1);
        end
        chk("rise_c0", r[0], 24);
        chk("rise_c1", r[1], 120);
        chk("rise_c2", r[2], 100);
        chk("rise_c3", r[3], 100);
        chk("rise_c4", r[4], 100);
        chk("c1_pattern", 32'(c1p), 32'h07);
        chk("c2_pattern", 32'(c2p), 32'h07);
        chk("c3_pattern", 32'(c3p), 32'h38);
        chk("c3_antiphase_misses", anti, 0);
        iARESET = 1'b1;
        step(1);
        chk1("areset_unlock", oLOCKED, 1'b0);
        chk("areset_clks", 32'({oC4, oC3, oC2, oC1, oC0}), 32'h0);
        step(1);
        iARESET = 1'b0;
        step(1023);
        chk1("relock_pre", oLOCKED, 1'b0);
        step(1);
        chk1("relock", oLOCKED, 1'b1);
        chk("relock_align", 32'({oC4, oC3, oC2, oC1, oC0}), 32'h17);
        iARESET = 1'b1;
        step(1);
        iARESET = 1'b0;
        step(1023);
        iARESET = 1'b1;
        step(1);
        chk1("terminal_vs_areset", oLOCKED, 1'b0);
        iARESET = 1'b0;
        step(1023);
        chk1("relock2_pre", oLOCKED, 1'b0);
        step(1);
        chk1("relock2", oLOCKED, 1'b1);
        for (int i = 0; i < 12 && !found; i++) begin
            if (oC1) found = 1'b1;
            else step(1);
        end
        chk1("c1_high_found", found, 1'b1);
        #2 iRESETn = 1'b0;
        #1 chk("async_reset", 32'({oLOCKED, oC4, oC3, oC2, oC1, oC0, oOSC_CLK}), 32'h0);
        osc_rand = 1'b0;
        @(negedge iCLK);
        iOSCENA = 1'b1;
        iRESETn = 1'b1;
        step(1);
        iARESET = 1'b1;
        step(1);
        repeat (16) begin
            hi += int'(oOSC_CLK);
            step(1);
        end
        chk("osc_duty_16", hi, 8);
        chk1("osc_areset_unlocked", oLOCKED, 1'b0);
        iOSCENA = 1'b0;
        step(1);
        repeat (5) begin
            lo += int'(oOSC_CLK);
            step(1);
        end
        chk("osc_frozen_low", lo, 0);
        iARESET = 1'b0;
        osc_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step($urandom_range(1030, 1300));
            iARESET = 1'b1;
            step($urandom_range(1, 3));
            iARESET = 1'b0;
        end
        step(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_clk_pll_model.md
Name: sys_clk_pll_model

Overview:
- Synthesizable digital stand-in for the board's system PLL plus internal oscillator.
- Runs from one fast reference clock and derives five integer-divided clock outputs (c0..c4), a lock indicator and a free-running oscillator output.
- Used in simulation and in FPGA-less builds so downstream video, SDRAM and flash logic sees the same clock topology as the vendor PLL.
- Reference clock iCLK is modelled at 600 MHz; defaults give 24 / 120 / 100 / 100 (phase-shifted) / 100 MHz and a 75 MHz oscillator.

Parameters:
- DIV0, 25, c0 divide ratio (video pixel clock, 24 MHz); all DIVn and OSC_DIV must be in 2..255.
- DIV1, 5, c1 divide ratio (video x5 clock, 120 MHz).
- DIV2, 6, c2 divide ratio (memory clock).
- DIV3, 6, c3 divide ratio (SDRAM pin clock).
- PHASE3, 3, c3 delay in iCLK cycles relative to c2, in 0..DIV3-1.
- DIV4, 6, c4 divide ratio (flash clock).
- LOCK_CYCLES, 1024, iCLK cycles from reset release to lock, in 1..65535.
- OSC_DIV, 8, oscillator divide ratio.

Ports:
- iCLK  in  1  reference clock, all logic on its rising edge.
- iRESETn  in  1  asynchronous active-low reset.
- iARESET  in  1  synchronous active-high PLL restart, equivalent to vendor areset.
- iOSCENA  in  1  oscillator enable.
- oC0..oC4  out  1 each  divided clock outputs.
- oLOCKED  out  1  outputs valid and stable.
- oOSC_CLK  out  1  oscillator output.

Behaviour:
- Reset (iRESETn=0, async): all outputs 0; all counters 0.
- Lock counter: a 16-bit counter increments each cycle while not locked.
  - oLOCKED rises on the edge where the count reaches LOCK_CYCLES-1, i.e. the first oLOCKED=1 cycle is LOCK_CYCLES cycles after reset release.
  - oLOCKED then holds until reset or iARESET.
- iARESET=1 sampled high:
  - next cycle oLOCKED=0, oC0..oC4=0, lock and divider counters cleared;
  - the lock sequence restarts on the first cycle iARESET is low.
  - iARESET does not affect the oscillator.
- Divider channel n: counter cnt runs 0..DIVn-1 and wraps.
  - Output is high when cnt < (DIVn+1)/2 using integer division. Even ratios give 50% duty; odd ratios are high one extra cycle (DIV1=5: 3 high, 2 low).
  - Counters are held at 0 and outputs forced low while oLOCKED=0.
  - On the first cycle with oLOCKED=1, all channels start at cnt=0, so oC0, oC1, oC2 and oC4 rise together.
- oC3: its counter is preloaded to (DIV3-PHASE3) mod DIV3 at lock. oC3 is therefore oC2-shaped but delayed by PHASE3 iCLK cycles; with defaults, exactly inverted (180°).
- Outputs are registered; there is no combinational path from inputs to outputs.
- Oscillator: counter 0..OSC_DIV-1 with the same duty rule, independent of lock.
  - iOSCENA=0: the counter freezes and oOSC_CLK is forced low on the next cycle.
  - Re-enabling resumes from the frozen count.
- Simultaneous lock-count terminal and iARESET: iARESET wins; oLOCKED stays 0.

Decomposition:
- Package sys_clk_pkg holds the default divide constants, LOCK_CYCLES default and counter width constant CNT_W=8.
- One sub-module, clk_div_chan, with parameters DIV and PRELOAD and inputs run/enable. It is instantiated six times: c0–c4 and the oscillator, with the oscillator's run tied to iOSCENA.
- The top level contains the lock counter, the iARESET handling and the instances.

Test Plan:
- Reset then release with iARESET=0 and LOCK_CYCLES=1024 -> oLOCKED=0 for 1023 cycles and 1 on cycle 1024; all oCn low before lock.
- After lock, count 600 iCLK cycles -> oC0 has 24 rising edges, oC1 120, oC2, oC3 and oC4 100 each. oC1 pattern is 3 high, 2 low; oC2 is 3 high, 3 low.
- Phase check -> oC3 equals oC2 delayed 3 cycles, i.e. oC3 = ~oC2 at every edge after the first 3 post-lock cycles.
- Assert iARESET for 2 cycles mid-run -> oLOCKED and all oCn drop low; relock occurs 1024 cycles after iARESET deasserts, and oC0, oC1, oC2 and oC4 rise aligned on the first cycle.
- iOSCENA toggling -> oOSC_CLK period is 8 cycles (4 high, 4 low) while enabled, low and frozen while disabled, and unaffected by iARESET.
- Assert iRESETn low asynchronously mid-high-phase -> all outputs go 0 immediately without a clock edge.
